// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes
// Copies one HD program block into instruction memory, one word per cycle.
// A start command (block number, word count, destination base) is latched in
// OCIOSO; sequential HD reads are issued, and each word returned one cycle
// later is written to instruction memory at the matching destination offset.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-low reset
//   iniciar                    start request (sampled only when idle)
//   numero_bloco               HD block to copy
//   quantidade_palavras        words to copy (0..TAMANHO_BLOCO)
//   endereco_base_inst         destination base in instruction memory
//   enderecoHD, leituraHD      HD read address / strobe
//   dadoHD                     HD read data (one cycle after strobe)
//   enderecoInst, dadoInst,
//   escritaInst                instruction memory write port
//   ocupado                    transfer in progress
//   concluido                  one-cycle pulse at the end of every command
//   erro                       word count too large; held until next command
//
// state    | meaning
// OCIOSO   | idle, waiting for iniciar
// LEITURA  | issuing HD reads for words 0..N-1
// ESVAZIAR | last read in flight, writing word N-1
// FIM      | concluido pulse, back to OCIOSO next cycle
module carregador_instrucoes #(
    parameter int unsigned TAMANHO_BLOCO = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [31:0] numero_bloco,
    input  logic [31:0] quantidade_palavras,
    input  logic [31:0] endereco_base_inst,
    output logic [31:0] enderecoHD,
    output logic        leituraHD,
    input  logic [31:0] dadoHD,
    output logic [31:0] enderecoInst,
    output logic [31:0] dadoInst,
    output logic        escritaInst,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LEITURA  = 2'd1,
        ESVAZIAR = 2'd2,
        FIM      = 2'd3
    } estado_t;

    estado_t     estado;
    estado_t     proximo;

    logic [31:0] base_hd;
    logic [31:0] base_inst;
    logic [31:0] quantidade;
    logic [31:0] k;
    logic [31:0] k_atraso;
    logic        escrita_atraso;
    logic        transferiu;

    logic        aceita;
    logic        comando_vazio;
    logic        comando_invalido;

    assign aceita           = (estado == OCIOSO) && iniciar;
    assign comando_vazio    = (quantidade_palavras == 32'd0);
    assign comando_invalido = (quantidade_palavras > 32'(TAMANHO_BLOCO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    if (comando_vazio || comando_invalido) begin
                        proximo = FIM;
                    end else begin
                        proximo = LEITURA;
                    end
                end
            end
            LEITURA: begin
                if (k == quantidade - 32'd1) begin
                    proximo = ESVAZIAR;
                end
            end
            ESVAZIAR: proximo = FIM;
            FIM:      proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    // Command latch, read counter and the one-cycle-delayed write path that
    // lines up with the fixed HD read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_hd        <= '0;
            base_inst      <= '0;
            quantidade     <= '0;
            k              <= '0;
            k_atraso       <= '0;
            escrita_atraso <= 1'b0;
            transferiu     <= 1'b0;
            erro           <= 1'b0;
        end else begin
            escrita_atraso <= (estado == LEITURA);
            k_atraso       <= k;
            if (aceita) begin
                base_hd    <= numero_bloco * 32'(TAMANHO_BLOCO);
                base_inst  <= endereco_base_inst;
                quantidade <= quantidade_palavras;
                k          <= '0;
                erro       <= comando_invalido;
                // FIM only reports busy when it closes a real transfer.
                transferiu <= !(comando_vazio || comando_invalido);
            end else if (estado == LEITURA) begin
                k <= k + 32'd1;
            end
        end
    end

    assign leituraHD    = (estado == LEITURA);
    assign enderecoHD   = leituraHD ? (base_hd + k) : '0;
    assign escritaInst  = escrita_atraso;
    assign enderecoInst = escrita_atraso ? (base_inst + k_atraso) : '0;
    assign dadoInst     = dadoHD;
    assign concluido    = (estado == FIM);
    assign ocupado      = (estado == LEITURA) || (estado == ESVAZIAR) ||
                          ((estado == FIM) && transferiu);

endmodule

// File: tb/tb_carregador_instrucoes.sv
module tb_carregador_instrucoes;

    localparam int unsigned BLOCO = 200;

    logic        clk;
    logic        reset;
    logic        iniciar;
    logic [31:0] numero_bloco;
    logic [31:0] quantidade_palavras;
    logic [31:0] endereco_base_inst;
    logic [31:0] enderecoHD;
    logic        leituraHD;
    logic [31:0] dadoHD;
    logic [31:0] enderecoInst;
    logic [31:0] dadoInst;
    logic        escritaInst;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    int checks;
    int failures;

    carregador_instrucoes #(.TAMANHO_BLOCO(BLOCO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .iniciar             (iniciar),
        .numero_bloco        (numero_bloco),
        .quantidade_palavras (quantidade_palavras),
        .endereco_base_inst  (endereco_base_inst),
        .enderecoHD          (enderecoHD),
        .leituraHD           (leituraHD),
        .dadoHD              (dadoHD),
        .enderecoInst        (enderecoInst),
        .dadoInst            (dadoInst),
        .escritaInst         (escritaInst),
        .ocupado             (ocupado),
        .concluido           (concluido),
        .erro                (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HD contents: a fixed scramble of the word address.
    function automatic logic [31:0] hd_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    // HD model with one-cycle read latency.
    always @(posedge clk) begin
        if (leituraHD) dadoHD <= hd_val(enderecoHD);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issues one command and checks every cycle from T+1 to one idle cycle
    // past concluido against the timing rules. If inj>0, a different command
    // is pulsed on iniciar during cycle T+inj and must be ignored.
    task automatic run_cmd(input logic [31:0] bloco, input logic [31:0] n,
                           input logic [31:0] base, input int inj);
        logic [31:0] bhd;
        logic        valido;
        logic        e_erro;
        int          nn;
        int          ultimo;
        logic        exp_rd, exp_wr;
        bhd    = bloco * BLOCO;
        valido = (n != 0) && (n <= BLOCO);
        e_erro = (n > BLOCO);
        nn     = valido ? int'(n) : 0;
        ultimo = valido ? nn + 2 : 1;

        @(negedge clk);
        iniciar             = 1'b1;
        numero_bloco        = bloco;
        quantidade_palavras = n;
        endereco_base_inst  = base;
        for (int c = 1; c <= ultimo + 1; c++) begin
            @(negedge clk);
            iniciar = 1'b0;
            exp_rd = valido && (c >= 1) && (c <= nn);
            exp_wr = valido && (c >= 2) && (c <= nn + 1);
            chk("leituraHD", 32'(leituraHD), 32'(exp_rd));
            if (exp_rd) chk("enderecoHD", enderecoHD, bhd + 32'(c - 1));
            chk("escritaInst", 32'(escritaInst), 32'(exp_wr));
            if (exp_wr) begin
                chk("enderecoInst", enderecoInst, base + 32'(c - 2));
                chk("dadoInst", dadoInst, hd_val(bhd + 32'(c - 2)));
            end
            chk("ocupado", 32'(ocupado), 32'(valido && (c <= ultimo)));
            chk("concluido", 32'(concluido), 32'(c == ultimo));
            chk("erro", 32'(erro), 32'(e_erro));
            if (c == inj) begin
                iniciar             = 1'b1;
                numero_bloco        = $urandom;
                quantidade_palavras = 32'($urandom_range(0, 3));
                endereco_base_inst  = $urandom;
            end
        end
    endtask

    task automatic reset_mid_transfer();
        @(negedge clk);
        iniciar             = 1'b1;
        numero_bloco        = 32'd7;
        quantidade_palavras = 32'd5;
        endereco_base_inst  = 32'h300;
        @(negedge clk);
        iniciar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_leitura", 32'(leituraHD), 32'd1);
        chk("rst_pre_enderecoHD", enderecoHD, 32'd7 * BLOCO + 32'd2);
        reset = 1'b0;
        #1;
        chk("rst_enderecoHD", enderecoHD, 32'd0);
        chk("rst_leituraHD", 32'(leituraHD), 32'd0);
        chk("rst_enderecoInst", enderecoInst, 32'd0);
        chk("rst_escritaInst", 32'(escritaInst), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_concluido", 32'(concluido), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_dadoInst", dadoInst, dadoHD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_escrita", 32'(escritaInst), 32'd0);
            chk("rst_hold_leitura", 32'(leituraHD), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pos_rst_escrita", 32'(escritaInst), 32'd0);
            chk("pos_rst_ocupado", 32'(ocupado), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] n;
        int          sel;
        int          inj;
        checks              = 0;
        failures            = 0;
        reset               = 1'b0;
        iniciar             = 1'b0;
        numero_bloco        = '0;
        quantidade_palavras = '0;
        endereco_base_inst  = '0;
        dadoHD              = '0;
        repeat (3) @(negedge clk);
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        chk("reset_concluido", 32'(concluido), 32'd0);
        chk("reset_erro", 32'(erro), 32'd0);
        chk("reset_leituraHD", 32'(leituraHD), 32'd0);
        chk("reset_escritaInst", 32'(escritaInst), 32'd0);
        reset = 1'b1;

        run_cmd(32'd2, 32'd3, 32'h10, 0);
        run_cmd(32'd5, 32'd0, 32'h20, 0);
        run_cmd(32'd5, 32'd201, 32'h20, 0);
        run_cmd(32'd1, 32'd1, 32'h40, 0);
        run_cmd(32'd0, 32'hFFFFFFFF, 32'h0, 0);
        run_cmd(32'd3, 32'd200, 32'h0, 0);
        run_cmd(32'd0, 32'd200, 32'hFFFFFFFE, 0);
        run_cmd(32'hFFFFFFFF, 32'd4, 32'h100, 2);
        run_cmd(32'd9, 32'd6, 32'h80, 5);
        reset_mid_transfer();
        run_cmd(32'd4, 32'd5, 32'h500, 0);

        for (int i = 0; i < 25; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      n = 32'd0;
            else if (sel == 1) n = 32'(BLOCO) + 32'($urandom_range(1, 5000));
            else if (sel == 2) n = 32'(BLOCO);
            else               n = 32'($urandom_range(1, 12));
            inj = 0;
            if (n != 0 && n <= BLOCO && $urandom_range(0, 1) == 1)
                inj = int'($urandom_range(1, int'(n) + 1));
            run_cmd($urandom, n, $urandom, inj);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
